// File: rtl/add_output_of_n_multipliers_acc_if.sv
// Bus bundle for the sum-of-products accumulator: operand lanes with their
// qualifiers in, registered result with its valid pulse and sticky overflow out.
interface add_output_of_n_multipliers_acc_if #(
  parameter int INPUT_WIDTH  = 14,
  parameter int NUM_MULT     = 4,
  parameter int OUTPUT_WIDTH = 32
);
  // in_valid qualifies a/b/acc_en for one cycle; there is no ready, every valid
  // beat is consumed on the edge it is presented. out_valid marks y as new.
  logic                            in_valid;
  logic                            acc_en;
  logic                            clear;
  logic [NUM_MULT*INPUT_WIDTH-1:0] a;
  logic [NUM_MULT*INPUT_WIDTH-1:0] b;
  logic [OUTPUT_WIDTH-1:0]         y;
  logic                            out_valid;
  logic                            overflow;

  modport master (
    output in_valid, acc_en, clear, a, b,
    input  y, out_valid, overflow
  );

  modport slave (
    input  in_valid, acc_en, clear, a, b,
    output y, out_valid, overflow
  );
endinterface

// File: rtl/add_output_of_n_multipliers_acc.sv
// N-lane sum-of-products with a three-stage pipeline (products, adder tree,
// accumulator) and a sticky overflow flag on accumulate wrap.
module add_output_of_n_multipliers_acc #(
  parameter int INPUT_WIDTH  = 14,
  parameter int NUM_MULT     = 4,
  parameter int OUTPUT_WIDTH = 32,
  parameter int SIGNED       = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  add_output_of_n_multipliers_acc_if.slave  bus
);

  localparam int PROD_W = 2 * INPUT_WIDTH;
  localparam int SUM_W  = PROD_W + $clog2(NUM_MULT);

  if (NUM_MULT < 1 || NUM_MULT > 16) begin : g_bad_num_mult
    $error("NUM_MULT must be within 1..16");
  end
  if (OUTPUT_WIDTH < SUM_W) begin : g_bad_output_width
    $error("OUTPUT_WIDTH is narrower than the adder-tree result");
  end

  logic [PROD_W-1:0]       prod_d [NUM_MULT];
  logic [PROD_W-1:0]       prod_q [NUM_MULT];
  logic                    v1_q, acc1_q;
  logic [SUM_W-1:0]        sum_d, sum_q;
  logic                    v2_q, acc2_q;
  logic [OUTPUT_WIDTH-1:0] sum_ext;
  logic [OUTPUT_WIDTH:0]   acc_sum;
  logic                    wrap;
  logic [OUTPUT_WIDTH-1:0] y_d, y_q;
  logic                    ovf_d, ovf_q;
  logic                    out_valid_q;

  // Operands are widened to PROD_W first; the low PROD_W bits of that product
  // are correct for both unsigned and two's-complement lanes.
  for (genvar i = 0; i < NUM_MULT; i++) begin : g_lane
    logic [INPUT_WIDTH-1:0] a_l, b_l;
    logic [PROD_W-1:0]      a_ext, b_ext;
    assign a_l       = bus.a[i*INPUT_WIDTH +: INPUT_WIDTH];
    assign b_l       = bus.b[i*INPUT_WIDTH +: INPUT_WIDTH];
    assign a_ext     = (SIGNED != 0) ? PROD_W'($signed(a_l)) : PROD_W'(a_l);
    assign b_ext     = (SIGNED != 0) ? PROD_W'($signed(b_l)) : PROD_W'(b_l);
    assign prod_d[i] = a_ext * b_ext;
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_MULT; i++) begin
      sum_d = sum_d + ((SIGNED != 0) ? SUM_W'($signed(prod_q[i])) : SUM_W'(prod_q[i]));
    end
  end

  assign sum_ext = (SIGNED != 0) ? OUTPUT_WIDTH'($signed(sum_q)) : OUTPUT_WIDTH'(sum_q);
  assign acc_sum = {1'b0, y_q} + {1'b0, sum_ext};
  assign wrap    = (SIGNED != 0)
                 ? ((y_q[OUTPUT_WIDTH-1] == sum_ext[OUTPUT_WIDTH-1]) &&
                    (acc_sum[OUTPUT_WIDTH-1] != y_q[OUTPUT_WIDTH-1]))
                 : acc_sum[OUTPUT_WIDTH];

  // clear beats any accumulate: a beat landing on a clear edge simply loads.
  always_comb begin
    y_d   = y_q;
    ovf_d = ovf_q;
    if (bus.clear) begin
      y_d   = v2_q ? sum_ext : '0;
      ovf_d = 1'b0;
    end else if (v2_q) begin
      if (acc2_q) begin
        y_d   = acc_sum[OUTPUT_WIDTH-1:0];
        ovf_d = ovf_q | wrap;
      end else begin
        y_d   = sum_ext;
        ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
    end else begin
      v1_q        <= bus.in_valid;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    prod_q <= prod_d;
    acc1_q <= bus.acc_en;
    sum_q  <= sum_d;
    acc2_q <= acc1_q;
  end

  assign bus.y         = y_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = ovf_q;

endmodule
